// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM state
// encoding and the address/data width.
package mem_arbiter_pkg;

    localparam int AW = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_timer.sv
// arb_timer: busy-cycle counter for the arbiter timeout (built only with
// MEM_ARB_TIMEOUT_EN). Ports: clk, rst, clear, enable in; expired out.
`ifdef MEM_ARB_TIMEOUT_EN
module arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    // count holds (busy cycle - 1), so this fires in busy cycle TIMEOUT
    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch (if_*) and the
// data stage (dm_*), data first. Ports: clk/rst, if_req/if_addr ->
// if_rdata/if_done, dm_rd/dm_wr/dm_addr/dm_wdata -> dm_rdata/dm_done,
// mem_rd/mem_wr/mem_addr/mem_wdata <- mem_rdata/mem_done, stall_if,
// stall_mem, err. Define MEM_ARB_TIMEOUT_EN to add a busy timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [AW-1:0] if_rdata,
    output logic          if_done,
    input  logic          dm_rd,
    input  logic          dm_wr,
    input  logic [AW-1:0] dm_addr,
    input  logic [AW-1:0] dm_wdata,
    output logic [AW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    input  logic [AW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          err
);

    state_t state;
    logic   busy;
    logic   expired;
    logic   err_pulse;

    assign busy = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    logic err_sticky;

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!busy),
        .enable  (busy),
        .expired (expired)
    );

    assign err = err_pulse | err_sticky;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT);
    assign expired        = 1'b0;
    assign err            = err_pulse;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            err_pulse <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            err_sticky <= 1'b0;
`endif
        end else begin
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            err_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The done-pulse cycle never grants; a request still
                    // high there is treated as a fresh one next cycle.
                    if (!(if_done || dm_done)) begin
                        if (dm_rd && dm_wr) begin
                            err_pulse <= 1'b1;
                        end
                        if (dm_rd ^ dm_wr) begin
                            state     <= DM_BUSY;
                            mem_rd    <= dm_rd;
                            mem_wr    <= dm_wr;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end else if (if_req) begin
                            state    <= IF_BUSY;
                            mem_rd   <= 1'b1;
                            mem_wr   <= 1'b0;
                            mem_addr <= if_addr;
                        end
                    end
                end
                IF_BUSY, DM_BUSY: begin
                    if (mem_done) begin
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (state == IF_BUSY) begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end else begin
                            if (mem_rd) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_done <= 1'b1;
                        end
                    end else if (expired) begin
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                        err_sticky <= 1'b1;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                end
            endcase
        end
    end

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = (dm_rd | dm_wr) & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then randomized
// concurrent fetch/data traffic against a behavioural memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_rd     (dm_rd),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } dm_exp_t;

    logic [15:0] if_q[$];
    dm_exp_t     dm_q[$];
    logic [15:0] dev_mem[logic [15:0]];
    logic [15:0] ref_wr[logic [15:0]];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int late_at = -1;
    int fixed_lat = -1;
    bit silent = 1'b0;
    bit active = 1'b0;
    int left = 0;
    int if_cnt = 0;
    int dm_cnt = 0;
    logic [15:0] last_dm = '0;
    logic [15:0] mon_if;
    dm_exp_t     mon_dm;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_wr.exists(a) ? ref_wr[a] : init_val(a);
    endfunction

    function automatic logic [15:0] dev_rd(input logic [15:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_if(input int lim, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (if_done !== 1'b1 && n < lim);
        if (if_done !== 1'b1) check(1'b0, "if_done_timeout", 64'(n), 64'(lim));
    endtask

    task automatic wait_dm(input int lim, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (dm_done !== 1'b1 && n < lim);
        if (dm_done !== 1'b1) check(1'b0, "dm_done_timeout", 64'(n), 64'(lim));
    endtask

    task automatic check_zero(input string name);
        check({mem_rd, mem_wr, mem_addr, mem_wdata, if_done, dm_done,
               if_rdata, dm_rdata, err} === '0, name,
              {mem_addr, if_rdata, dm_rdata, 5'b0,
               mem_rd, mem_wr, if_done, dm_done, err}, 64'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory device: random or fixed latency, one mem_done per access.
    initial begin
        mem_done  = 1'b0;
        mem_rdata = '0;
        forever begin
            tick();
            mem_done = 1'b0;
            if (cyc == late_at) begin
                mem_done  = 1'b1;
                mem_rdata = 16'hDEAD;
            end else if (!silent && (mem_rd || mem_wr)) begin
                if (!active) begin
                    active = 1'b1;
                    left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
                end
                if (left == 0) begin
                    mem_done  = 1'b1;
                    mem_rdata = mem_wr ? 16'($urandom) : dev_rd(mem_addr);
                    if (mem_wr) dev_mem[mem_addr] = mem_wdata;
                    active = 1'b0;
                end else begin
                    left--;
                end
            end else if (!(mem_rd || mem_wr)) begin
                active = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a completion appears.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) last_dm = '0;
            if (if_done === 1'b1) begin
                if_cnt++;
                if (if_q.size() == 0) begin
                    check(1'b0, "if_spurious_done", 64'd1, 64'd0);
                end else begin
                    mon_if = if_q.pop_front();
                    check(if_rdata === mon_if, "if_rdata", 64'(if_rdata), 64'(mon_if));
                end
            end
            if (dm_done === 1'b1) begin
                dm_cnt++;
                if (dm_q.size() == 0) begin
                    check(1'b0, "dm_spurious_done", 64'd1, 64'd0);
                end else begin
                    mon_dm = dm_q.pop_front();
                    if (mon_dm.wr) begin
                        check(dm_rdata === last_dm, "dm_rdata_kept_on_write",
                              64'(dm_rdata), 64'(last_dm));
                        check(dev_rd(mon_dm.addr) === mon_dm.data, "dm_write_mem",
                              64'(dev_rd(mon_dm.addr)), 64'(mon_dm.data));
                    end else begin
                        check(dm_rdata === mon_dm.data, "dm_rdata",
                              64'(dm_rdata), 64'(mon_dm.data));
                        last_dm = mon_dm.data;
                    end
                end
            end
            if (if_done === 1'b1) check(stall_if === 1'b0, "stall_if_on_done", 64'(stall_if), 64'd0);
            else if (if_req) check(stall_if === 1'b1, "stall_if_pending", 64'(stall_if), 64'd1);
            else check(stall_if === 1'b0, "stall_if_idle", 64'(stall_if), 64'd0);
            if (dm_done === 1'b1) check(stall_mem === 1'b0, "stall_mem_on_done", 64'(stall_mem), 64'd0);
            else if (dm_rd || dm_wr) check(stall_mem === 1'b1, "stall_mem_pending", 64'(stall_mem), 64'd1);
            else check(stall_mem === 1'b0, "stall_mem_idle", 64'(stall_mem), 64'd0);
            if (mem_rd === 1'b1 || mem_wr === 1'b1)
                check(!(mem_rd && mem_wr), "strobe_exclusive", {mem_rd, mem_wr}, 64'd2);
        end
    end

    task automatic fetch_proc();
        int n;
        logic [15:0] a;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom_range(0, 255));
            if_q.push_back(ref_rd(a));
            if_addr = a;
            if_req  = 1'b1;
            wait_if(300, n);
            if_req = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic data_proc();
        int n;
        bit wr;
        logic [15:0] a;
        logic [15:0] d;
        for (int i = 0; i < 40; i++) begin
            a  = 16'h0200 | 16'($urandom_range(0, 255));
            wr = ($urandom_range(0, 2) == 0);
            d  = 16'($urandom);
            if (wr) begin
                ref_wr[a] = d;
                dm_q.push_back('{1'b1, a, d});
            end else begin
                dm_q.push_back('{1'b0, a, ref_rd(a)});
            end
            dm_addr  = a;
            dm_wdata = d;
            dm_rd    = !wr;
            dm_wr    = wr;
            wait_dm(300, n);
            dm_rd = 1'b0;
            dm_wr = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        rst = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        dm_rd = 1'b0;
        dm_wr = 1'b0;
        dm_addr = '0;
        dm_wdata = '0;
        idle(3);
        rst = 1'b0;
        check_zero("reset_outputs");
        idle(2);

        // Fetch with mem_done two cycles after mem_rd
        fixed_lat = 2;
        dev_mem[16'h0010] = 16'hABCD;
        ref_wr[16'h0010] = 16'hABCD;
        if_q.push_back(16'hABCD);
        c0 = if_cnt;
        if_req = 1'b1;
        if_addr = 16'h0010;
        tick();
        check(mem_rd === 1'b1 && mem_addr === 16'h0010, "a_mem_addr", 64'(mem_addr), 64'h10);
        wait_if(20, n);
        check(n == 3, "a_latency", 64'(n), 64'd3);
        check(if_rdata === 16'hABCD, "a_if_rdata", 64'(if_rdata), 64'hABCD);
        if_req = 1'b0;
        idle(4);
        check(if_cnt == c0 + 1, "a_single_done", 64'(if_cnt - c0), 64'd1);

        // Simultaneous fetch and data read: data wins
        fixed_lat = 0;
        if_q.push_back(ref_rd(16'h0020));
        dm_q.push_back('{1'b0, 16'h0200, ref_rd(16'h0200)});
        if_req = 1'b1;
        if_addr = 16'h0020;
        dm_rd = 1'b1;
        dm_addr = 16'h0200;
        tick();
        check(mem_rd === 1'b1 && mem_addr === 16'h0200, "b_data_first", 64'(mem_addr), 64'h200);
        wait_dm(20, n);
        check(n == 1, "b_dm_latency", 64'(n), 64'd1);
        dm_rd = 1'b0;
        tick();
        check(mem_rd === 1'b0 && mem_wr === 1'b0, "b_no_grant_in_done", {mem_rd, mem_wr}, 64'd0);
        tick();
        check(mem_rd === 1'b1 && mem_addr === 16'h0020, "b_fetch_grant", 64'(mem_addr), 64'h20);
        wait_if(20, n);
        check(n == 1, "b_if_latency", 64'(n), 64'd1);
        if_req = 1'b0;
        idle(3);

        // Data write: strobes held, dm_rdata untouched
        fixed_lat = 3;
        ref_wr[16'h0040] = 16'h1234;
        dm_q.push_back('{1'b1, 16'h0040, 16'h1234});
        c0 = dm_cnt;
        dm_wr = 1'b1;
        dm_addr = 16'h0040;
        dm_wdata = 16'h1234;
        n = 0;
        do begin
            tick();
            n++;
            if (dm_done !== 1'b1)
                check(mem_wr === 1'b1 && mem_rd === 1'b0 && mem_addr === 16'h0040 &&
                      mem_wdata === 16'h1234, "c_write_strobe",
                      {mem_rd, mem_wr, mem_addr, mem_wdata}, {2'b01, 16'h0040, 16'h1234});
        end while (dm_done !== 1'b1 && n < 20);
        check(n == 5, "c_latency", 64'(n), 64'd5);
        dm_wr = 1'b0;
        idle(3);
        check(dm_cnt == c0 + 1, "c_single_done", 64'(dm_cnt - c0), 64'd1);

        // Read and write together: error pulse, no grant
        c0 = dm_cnt;
        dm_rd = 1'b1;
        dm_wr = 1'b1;
        dm_addr = 16'h0230;
        tick();
        check(err === 1'b1 && mem_rd === 1'b0 && mem_wr === 1'b0, "d_err_pulse",
              {err, mem_rd, mem_wr}, 64'd4);
        dm_rd = 1'b0;
        dm_wr = 1'b0;
        tick();
        check(err === 1'b0 && mem_rd === 1'b0 && mem_wr === 1'b0, "d_err_clear",
              {err, mem_rd, mem_wr}, 64'd0);
        idle(2);
        check(dm_cnt == c0, "d_no_done", 64'(dm_cnt - c0), 64'd0);

        // Reset in the middle of a data access, then a late mem_done
        silent = 1'b1;
        dm_rd = 1'b1;
        dm_addr = 16'h0210;
        tick();
        check(mem_rd === 1'b1, "e_busy", 64'(mem_rd), 64'd1);
        tick();
        rst = 1'b1;
        dm_rd = 1'b0;
        tick();
        rst = 1'b0;
        check_zero("e_reset_outputs");
        late_at = cyc + 1;
        c0 = dm_cnt;
        idle(4);
        check(dm_cnt == c0, "e_no_done", 64'(dm_cnt - c0), 64'd0);
        check(mem_rd === 1'b0 && mem_wr === 1'b0, "e_stay_idle", {mem_rd, mem_wr}, 64'd0);
        late_at = -1;
        silent = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
        silent = 1'b1;
        c0 = dm_cnt;
        dm_rd = 1'b1;
        dm_addr = 16'h0250;
        n = 0;
        do begin
            tick();
            n++;
        end while (err !== 1'b1 && n < 30);
        check(n == 9, "f_timeout_cycle", 64'(n), 64'd9);
        check(mem_rd === 1'b0 && mem_wr === 1'b0, "f_strobes_drop", {mem_rd, mem_wr}, 64'd0);
        dm_rd = 1'b0;
        idle(5);
        check(err === 1'b1, "f_err_sticky", 64'(err), 64'd1);
        check(dm_cnt == c0, "f_no_done", 64'(dm_cnt - c0), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check(err === 1'b0, "f_err_cleared", 64'(err), 64'd0);
        silent = 1'b0;
`else
        silent = 1'b1;
        dm_q.push_back('{1'b0, 16'h0250, ref_rd(16'h0250)});
        dm_rd = 1'b1;
        dm_addr = 16'h0250;
        idle(100);
        check(mem_rd === 1'b1 && err === 1'b0 && dm_done === 1'b0, "f_still_waiting",
              {mem_rd, err, dm_done}, 64'd4);
        silent = 1'b0;
        wait_dm(20, n);
        dm_rd = 1'b0;
`endif
        idle(3);

        // Randomized concurrent traffic
        fixed_lat = -1;
        fork
            fetch_proc();
            data_proc();
        join
        idle(10);
        check(if_q.size() == 0, "if_queue_drained", 64'(if_q.size()), 64'd0);
        check(dm_q.size() == 0, "dm_queue_drained", 64'(dm_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum busy cycles allowed before a timeout error (used only when the timeout feature is compiled in).
REQ-002 SHALL have port clk, input, 1, single clock; reset is synchronous and active-high.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port if_req, input, 1, fetch read request, held until if_done.
REQ-005 SHALL have port if_addr, input, 16, fetch address.
REQ-006 SHALL have port if_rdata, output, 16, fetch read data, valid with if_done.
REQ-007 SHALL have port if_done, output, 1, one-cycle fetch completion pulse.
REQ-008 SHALL have ports dm_rd and dm_wr, input, 1 each, data-stage read and write requests, held until dm_done.
REQ-009 SHALL have ports dm_addr and dm_wdata, input, 16 each, data address and data to write.
REQ-010 SHALL have port dm_rdata, output, 16, data read result, valid with dm_done.
REQ-011 SHALL have port dm_done, output, 1, one-cycle data completion pulse.
REQ-012 SHALL have ports mem_rd and mem_wr, output, 1 each, single-port memory strobes, held for the whole access.
REQ-013 SHALL have ports mem_addr and mem_wdata, output, 16 each, memory address and memory write data.
REQ-014 SHALL have ports mem_rdata (input, 16, memory read data) and mem_done (input, 1, memory completion pulse, arrives after 1..N cycles).
REQ-015 SHALL have port stall_if, output, 1, high while a fetch request is pending and not yet done.
REQ-016 SHALL have port stall_mem, output, 1, high while a data request is pending and not yet done.
REQ-017 SHALL have port err, output, 1, error flag that is ORed into the processor err.

Function
REQ-018 SHALL implement the FSM states IDLE, IF_BUSY and DM_BUSY.
REQ-019 SHALL, in IDLE with dm_rd|dm_wr asserted, latch addr/wdata/op and move to DM_BUSY; otherwise, if if_req is asserted, latch if_addr and move to IF_BUSY.
REQ-020 SHALL use strict priority for the data stage over fetch when both request in the same cycle, because data is the older instruction.
REQ-021 SHALL drive mem_rd/mem_wr/mem_addr/mem_wdata from registers only, asserted from the cycle after the grant until the cycle mem_done is seen inclusive.
REQ-022 SHALL, on mem_done in IF_BUSY, register mem_rdata into if_rdata, pulse if_done the next cycle, and return to IDLE.
REQ-023 SHALL, on mem_done in DM_BUSY, register mem_rdata into dm_rdata for reads (dm_rdata unchanged for writes), pulse dm_done the next cycle, and return to IDLE.
REQ-024 SHALL take minimum 3 cycles from request to done: grant, memory cycle with mem_done, done pulse.
REQ-025 SHALL keep if_rdata/dm_rdata stable until the next completion of the same requester.
REQ-026 SHALL NOT evaluate a new grant in the done-pulse cycle, which is IDLE with the done flag registered; a request still high there is a new request.
REQ-027 SHALL ignore mem_done while in IDLE.
REQ-028 SHALL, when dm_rd and dm_wr are both high in IDLE, not grant the request, pulse err for 1 cycle, and allow fetch to be granted instead.
REQ-029 SHALL make stall_if = if_req & ~if_done and stall_mem = (dm_rd|dm_wr) & ~dm_done, combinationally.

Reset
REQ-030 SHALL, on rst, go to IDLE next edge and clear to 0: mem_rd, mem_wr, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata and err.
REQ-031 SHALL, on rst mid-access, abandon the access, not pulse done, and ignore a late mem_done.

Configuration
REQ-032 SHALL, when MEM_ARB_TIMEOUT_EN is defined, count cycles in IF_BUSY/DM_BUSY; reaching TIMEOUT without mem_done sets err sticky until rst, deasserts strobes, returns to IDLE and issues no done.
REQ-033 SHALL, when MEM_ARB_TIMEOUT_EN is undefined, have no counter, wait indefinitely for mem_done, and drive err only per REQ-028.

Structure
REQ-034 SHALL place the state encoding (2-bit IDLE=0, IF_BUSY=1, DM_BUSY=2) and the address/data width constant (16) in shared package mem_arbiter_pkg.
REQ-035 SHALL use one sub-module, arb_timer (the cycle counter with clear, enable and expired output), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-036 SHALL cover: if_req, if_addr=0x0010, mem_done 2 cycles after mem_rd with mem_rdata=0xABCD -> mem_addr=0x0010, if_rdata=0xABCD, single if_done pulse, stall_if high until then.
REQ-037 SHALL cover: if_req and dm_rd (dm_addr=0x0200) in the same cycle -> data served first, then fetch granted the cycle after dm_done; if_done follows.
REQ-038 SHALL cover: dm_wr, dm_addr=0x0040, dm_wdata=0x1234 -> mem_wr=1 with those values until mem_done; dm_rdata unchanged; one dm_done.
REQ-039 SHALL cover: dm_rd=dm_wr=1 in IDLE -> no mem strobe, 1-cycle err pulse.
REQ-040 SHALL cover: rst asserted during DM_BUSY, then mem_done next cycle -> IDLE, all outputs 0, no dm_done.
REQ-041 SHALL cover, with MEM_ARB_TIMEOUT_EN and TIMEOUT=8: mem_done never asserted -> err high at busy cycle 8 and stays high, strobes drop; without the macro, still waiting at cycle 100.
